neuron_activation_unit: RTL and testbench

- Activation stage of one ELM hidden neuron. Takes the neuron's wide signed accumulator (weighted sum plus bias) and produces three activations in parallel: ReLU, full-table sigmoid ROM, and half-table sigmoid ROM that uses sign symmetry.
- A build-time parameter selects which activation drives the neuron output.
- Sits between the neuron MAC/accumulator and the layer output bus.

---
 rtl/neuron_activation_unit.sv | 139 +++++++++++++
 tb/tb_neuron_activation_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_activation_unit.sv
`timescale 1ns/1ps
// Activation stage of one ELM hidden neuron: ReLU, full sigmoid ROM and half (symmetric) sigmoid ROM.
// Latency 1 cycle on every path; no backpressure, out_valid is in_valid delayed by one cycle.
module neuron_activation_unit #(
    parameter int    DATA_WIDTH       = 16,
    parameter int    FRAC_WIDTH       = 12,
    parameter int    WEIGHT_INT_WIDTH = 4,
    parameter int    SIG_IN_WIDTH     = 10,
    parameter string ACT_TYPE         = "sigmoid_half"
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [2*DATA_WIDTH-1:0] sum,
    input  logic                          in_valid,
    output logic [DATA_WIDTH-1:0]         relu_out,
    output logic [DATA_WIDTH-1:0]         sig_out,
    output logic [DATA_WIDTH-1:0]         sig_half_out,
    output logic [DATA_WIDTH-1:0]         act_out,
    output logic                          out_valid
);

    localparam int SW         = 2 * DATA_WIDTH;
    localparam int XM         = SW - 1 - WEIGHT_INT_WIDTH;
    localparam int XL         = XM - SIG_IN_WIDTH + 1;
    localparam int STEP_SHIFT = 2 * FRAC_WIDTH - XL;
    localparam int FULL_DEPTH = 1 << SIG_IN_WIDTH;
    localparam int HALF_DEPTH = FULL_DEPTH / 2;
    localparam int ONE        = 1 << FRAC_WIDTH;
    localparam int RELU_MAX   = (1 << (DATA_WIDTH - 1)) - 1;
    localparam int RELU_TOP   = FRAC_WIDTH + DATA_WIDTH - 1;

    // round(ONE / (1 + exp(-x * 2^-STEP_SHIFT))) in Q62 integer arithmetic so it folds at elaboration.
    function automatic logic [DATA_WIDTH-1:0] sig_entry(input int x);
        logic [127:0] one_q;
        logic [127:0] e_step;
        logic [127:0] term;
        logic [127:0] p;
        logic [127:0] b;
        logic [127:0] num;
        logic [127:0] den;
        logic [31:0]  m;
        one_q  = 128'd1 << 62;
        e_step = one_q;
        term   = one_q;
        for (int k = 1; k <= 12; k++) begin
            term = term / (128'(k) << STEP_SHIFT);
            if (k % 2 == 1) e_step = e_step - term;
            else            e_step = e_step + term;
        end
        m = 32'((x < 0) ? -x : x);
        p = one_q;
        b = e_step;
        for (int k = 0; k <= SIG_IN_WIDTH; k++) begin
            if (m[k]) p = (p * b) >> 62;
            b = (b * b) >> 62;
        end
        den = one_q + p;
        num = (x < 0) ? (128'(ONE) * p) : (128'(ONE) << 62);
        return DATA_WIDTH'((2 * num + den) / (2 * den));
    endfunction

    logic [DATA_WIDTH-1:0] full_rom [FULL_DEPTH];
    logic [DATA_WIDTH-1:0] half_rom [HALF_DEPTH];

    for (genvar i = 0; i < FULL_DEPTH; i++) begin : g_full
        localparam int XV = (i < HALF_DEPTH) ? i : i - FULL_DEPTH;
        localparam logic [DATA_WIDTH-1:0] V = sig_entry(XV);
        assign full_rom[i] = V;
    end

    for (genvar i = 0; i < HALF_DEPTH; i++) begin : g_half
        localparam logic [DATA_WIDTH-1:0] V = sig_entry(i);
        assign half_rom[i] = V;
    end

    logic                    overflow;
    logic [SIG_IN_WIDTH-1:0] x_idx;
    logic [SIG_IN_WIDTH-1:0] neg_x;
    logic [SIG_IN_WIDTH-2:0] half_addr;
    logic [DATA_WIDTH-1:0]   half_val;
    logic [DATA_WIDTH-1:0]   relu_val;
    logic                    unused_low_bits;

    assign overflow        = !((&sum[SW-1:XM]) || !(|sum[SW-1:XM]));
    assign unused_low_bits = ^sum[FRAC_WIDTH-1:0];

    always_comb begin
        x_idx = sum[XM -: SIG_IN_WIDTH];
        if (overflow) begin
            x_idx = sum[SW-1] ? {1'b1, {(SIG_IN_WIDTH-1){1'b0}}}
                              : {1'b0, {(SIG_IN_WIDTH-1){1'b1}}};
        end
    end

    // The most negative index has no positive mirror; it reuses the last half-table entry.
    always_comb begin
        neg_x     = -x_idx;
        half_addr = x_idx[SIG_IN_WIDTH-2:0];
        if (x_idx[SIG_IN_WIDTH-1]) begin
            half_addr = neg_x[SIG_IN_WIDTH-1] ? {(SIG_IN_WIDTH-1){1'b1}} : neg_x[SIG_IN_WIDTH-2:0];
        end
        half_val = x_idx[SIG_IN_WIDTH-1] ? DATA_WIDTH'(ONE) - half_rom[half_addr]
                                         : half_rom[half_addr];
    end

    always_comb begin
        if (sum[SW-1])
            relu_val = '0;
        else if (|sum[SW-2:RELU_TOP])
            relu_val = DATA_WIDTH'(RELU_MAX);
        else
            relu_val = {1'b0, sum[RELU_TOP-1:FRAC_WIDTH]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            relu_out     <= '0;
            sig_out      <= '0;
            sig_half_out <= '0;
            out_valid    <= 1'b0;
        end else begin
            relu_out     <= relu_val;
            sig_out      <= full_rom[x_idx];
            sig_half_out <= half_val;
            out_valid    <= in_valid;
        end
    end

    if (ACT_TYPE == "relu") begin : g_act_relu
        assign act_out = relu_out;
    end else if (ACT_TYPE == "sigmoid") begin : g_act_sig
        assign act_out = sig_out;
    end else if (ACT_TYPE == "sigmoid_half") begin : g_act_half
        assign act_out = sig_half_out;
    end else begin : g_act_none
        assign act_out = '0;
    end

endmodule

// File: tb/tb_neuron_activation_unit.sv
`timescale 1ns/1ps
// Directed bench for neuron_activation_unit: one task per scenario, plus a full index sweep.
module tb_neuron_activation_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] sum;

    logic [15:0] relu_out, sig_out, sig_half_out, act_out;
    logic        out_valid;
    logic [15:0] r_act, s_act, b_act;
    logic [15:0] r_unused_relu, r_unused_sig, r_unused_half;
    logic [15:0] s_unused_relu, s_unused_sig, s_unused_half;
    logic [15:0] b_unused_relu, b_unused_sig, b_unused_half;
    logic        r_unused_vld, s_unused_vld, b_unused_vld;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    neuron_activation_unit u_dut (
        .clk(clk), .rst(rst), .sum(sum), .in_valid(in_valid),
        .relu_out(relu_out), .sig_out(sig_out), .sig_half_out(sig_half_out),
        .act_out(act_out), .out_valid(out_valid)
    );

    neuron_activation_unit #(.ACT_TYPE("relu")) u_relu (
        .clk(clk), .rst(rst), .sum(sum), .in_valid(in_valid),
        .relu_out(r_unused_relu), .sig_out(r_unused_sig), .sig_half_out(r_unused_half),
        .act_out(r_act), .out_valid(r_unused_vld)
    );

    neuron_activation_unit #(.ACT_TYPE("sigmoid")) u_sig (
        .clk(clk), .rst(rst), .sum(sum), .in_valid(in_valid),
        .relu_out(s_unused_relu), .sig_out(s_unused_sig), .sig_half_out(s_unused_half),
        .act_out(s_act), .out_valid(s_unused_vld)
    );

    neuron_activation_unit #(.ACT_TYPE("tanh")) u_bad (
        .clk(clk), .rst(rst), .sum(sum), .in_valid(in_valid),
        .relu_out(b_unused_relu), .sig_out(b_unused_sig), .sig_half_out(b_unused_half),
        .act_out(b_act), .out_valid(b_unused_vld)
    );

    function automatic int ref_sig(int x);
        real r;
        r = 4096.0 / (1.0 + $exp(-real'(x) / 64.0));
        return $rtoi(r + 0.5);
    endfunction

    function automatic int ref_half(int x);
        int m;
        if (x >= 0) return ref_sig(x);
        m = -x;
        if (m > 511) m = 511;
        return 4096 - ref_sig(m);
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; sum = 32'h0100_0000;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({relu_out, sig_out, sig_half_out, act_out} !== 64'd0) begin
                fails++;
                $display("FAIL reset_outputs cycle %0d: got relu=%0d sig=%0d half=%0d act=%0d, expected all 0",
                         c, relu_out, sig_out, sig_half_out, act_out);
            end
            checks++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL reset_valid cycle %0d: got %b, expected 0", c, out_valid);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_valid: got %b, expected 1", out_valid);
        end
        checks++;
        if (relu_out !== 16'd4096) begin
            fails++;
            $display("FAIL reset_release_relu: got %0d, expected 4096", relu_out);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_zero();
        sum = 32'h0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (relu_out !== 16'd0) begin
            fails++; $display("FAIL zero_relu: got %0d, expected 0", relu_out);
        end
        checks++;
        if (sig_out !== 16'd2048) begin
            fails++; $display("FAIL zero_sig: got %0d, expected 2048", sig_out);
        end
        checks++;
        if (sig_half_out !== 16'd2048) begin
            fails++; $display("FAIL zero_sig_half: got %0d, expected 2048", sig_half_out);
        end
        checks++;
        if (out_valid !== 1'b1) begin
            fails++; $display("FAIL zero_valid_high: got %b, expected 1", out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL zero_valid_pulse: got %b, expected 0", out_valid);
        end
    endtask

    // Each row: sum, relu, sig, sig_half (hand-computed).
    task automatic test_values(input string name, input logic [31:0] vec [], input int exp [][3]);
        for (int i = 0; i < vec.size(); i++) begin
            sum = vec[i]; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            checks++;
            if (relu_out !== 16'(exp[i][0])) begin
                fails++; $display("FAIL %s_relu sum=%h: got %0d, expected %0d", name, vec[i], relu_out, exp[i][0]);
            end
            checks++;
            if (sig_out !== 16'(exp[i][1])) begin
                fails++; $display("FAIL %s_sig sum=%h: got %0d, expected %0d", name, vec[i], sig_out, exp[i][1]);
            end
            checks++;
            if (sig_half_out !== 16'(exp[i][2])) begin
                fails++; $display("FAIL %s_sig_half sum=%h: got %0d, expected %0d", name, vec[i], sig_half_out, exp[i][2]);
            end
            checks++;
            if (act_out !== 16'(exp[i][2])) begin
                fails++; $display("FAIL %s_act sum=%h: got %0d, expected %0d", name, vec[i], act_out, exp[i][2]);
            end
        end
    endtask

    task automatic test_positive();
        logic [31:0] v [] = '{32'h0100_0000, 32'h0300_0000};
        int          e [][3] = '{'{4096, 2994, 2994}, '{12288, 3902, 3902}};
        test_values("positive", v, e);
    endtask

    task automatic test_negative();
        logic [31:0] v [] = '{32'hFFFF_FFFF, 32'hFF00_0000};
        int          e [][3] = '{'{0, 2032, 2032}, '{0, 1102, 1102}};
        test_values("negative", v, e);
    endtask

    task automatic test_saturation();
        logic [31:0] v [] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0800_0000,
                              32'h07FF_FFFF, 32'hF800_0000, 32'hF7FF_FFFF};
        int          e [][3] = '{'{32767, 4095, 4095}, '{0, 1, 1}, '{32767, 4095, 4095},
                                 '{32767, 4095, 4095}, '{0, 1, 1}, '{0, 1, 1}};
        test_values("saturation", v, e);
    endtask

    task automatic test_back_to_back();
        logic [31:0] v [3] = '{32'h0, 32'h0100_0000, 32'hFF00_0000};
        int          er [3] = '{0, 4096, 0};
        int          es [3] = '{2048, 2994, 1102};
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sum = v[i];
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1) begin
                fails++; $display("FAIL b2b_valid step %0d: got %b, expected 1", i, out_valid);
            end
            checks++;
            if (relu_out !== 16'(er[i])) begin
                fails++; $display("FAIL b2b_relu step %0d: got %0d, expected %0d", i, relu_out, er[i]);
            end
            checks++;
            if (sig_out !== 16'(es[i]) || sig_half_out !== 16'(es[i])) begin
                fails++; $display("FAIL b2b_sig step %0d: got %0d/%0d, expected %0d", i, sig_out, sig_half_out, es[i]);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL b2b_valid_end: got %b, expected 0", out_valid);
        end
    endtask

    task automatic test_act_type();
        sum = 32'h0300_0000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (r_act !== 16'd12288) begin
            fails++; $display("FAIL act_relu: got %0d, expected 12288", r_act);
        end
        checks++;
        if (s_act !== 16'd3902) begin
            fails++; $display("FAIL act_sigmoid: got %0d, expected 3902", s_act);
        end
        checks++;
        if (act_out !== 16'd3902) begin
            fails++; $display("FAIL act_sigmoid_half: got %0d, expected 3902", act_out);
        end
        checks++;
        if (b_act !== 16'd0) begin
            fails++; $display("FAIL act_illegal: got %0d, expected 0", b_act);
        end
    endtask

    task automatic test_sweep();
        int es, eh, er;
        for (int x = -512; x < 512; x++) begin
            sum = 32'(x * 262144); in_valid = 1'b1;
            @(posedge clk); #1;
            es = ref_sig(x);
            eh = ref_half(x);
            er = (x < 0) ? 0 : x * 64;
            checks++;
            if (sig_out !== 16'(es)) begin
                fails++; $display("FAIL sweep_sig x=%0d: got %0d, expected %0d", x, sig_out, es);
            end
            checks++;
            if (sig_half_out !== 16'(eh)) begin
                fails++; $display("FAIL sweep_sig_half x=%0d: got %0d, expected %0d", x, sig_half_out, eh);
            end
            checks++;
            if (relu_out !== 16'(er) || r_act !== 16'(er)) begin
                fails++; $display("FAIL sweep_relu x=%0d: got %0d/%0d, expected %0d", x, relu_out, r_act, er);
            end
            checks++;
            if (act_out !== 16'(eh) || s_act !== 16'(es) || b_act !== 16'd0) begin
                fails++; $display("FAIL sweep_act x=%0d: got half=%0d sig=%0d bad=%0d, expected %0d %0d 0",
                                  x, act_out, s_act, b_act, eh, es);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; sum = 32'h0;
        test_reset();
        test_zero();
        test_positive();
        test_negative();
        test_saturation();
        test_back_to_back();
        test_act_type();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
